// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch responder.
//   NOP_INSTR    : value presented on the instruction bus when no entry is valid
//   IMEM_ADDR_W  : instruction word address width
//   INSTR_W      : instruction width
//   OPCODE_MSB/LSB : opcode field position inside an instruction
//   FIFO_DEPTH   : response buffer depth (covers one stalled in-flight read)
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0;
    localparam int          IMEM_ADDR_W = 12;
    localparam int          INSTR_W     = 32;
    localparam int          OPCODE_MSB  = 31;
    localparam int          OPCODE_LSB  = 27;
    localparam int          FIFO_DEPTH  = 2;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry {data, addr} skid FIFO holding fetched instructions for decode.
// Entry 0 is always the head; a pop shifts the upper entry down, so the head
// comes straight from storage registers.
//   clock, reset          : clock, asynchronous active-high reset
//   push, push_data/addr  : write one entry at the tail
//   pop                   : drop the head entry
//   clear                 : discard all entries (takes priority over push/pop)
//   head_data, head_addr  : head entry contents (meaningful when count != 0)
//   count                 : number of valid entries, 0..2
module fetch_skid_fifo
    import fetch_pkg::*;
#(
    parameter int DATA_W = INSTR_W,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop,
    input  logic              clear,
    output logic [DATA_W-1:0] head_data,
    output logic [ADDR_W-1:0] head_addr,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] data_reg  [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_reg  [FIFO_DEPTH];
    logic [DATA_W-1:0] data_next [FIFO_DEPTH];
    logic [ADDR_W-1:0] addr_next [FIFO_DEPTH];
    logic [1:0]        count_reg;
    logic [1:0]        count_next;
    logic [1:0]        wr_idx;

    // After a simultaneous pop the tail slot moves down by one.
    assign wr_idx = count_reg - {1'b0, pop};

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = 2'd0;
        end else if (push && !pop) begin
            count_next = count_reg + 2'd1;
        end else if (pop && !push) begin
            count_next = count_reg - 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            localparam logic [1:0] SLOT = 2'(gi);
            // Shift source: the next slot up; the top slot just holds.
            localparam int SRC = (gi < FIFO_DEPTH - 1) ? gi + 1 : gi;

            assign data_next[gi] = clear                    ? data_reg[gi]  :
                                   (push && wr_idx == SLOT) ? push_data     :
                                   pop                      ? data_reg[SRC] :
                                                              data_reg[gi];
            assign addr_next[gi] = clear                    ? addr_reg[gi]  :
                                   (push && wr_idx == SLOT) ? push_addr     :
                                   pop                      ? addr_reg[SRC] :
                                                              addr_reg[gi];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_reg[i] <= '0;
                addr_reg[i] <= '0;
            end
        end else begin
            count_reg <= count_next;
            data_reg  <= data_next;
            addr_reg  <= addr_next;
        end
    end

    assign head_data = data_reg[0];
    assign head_addr = addr_reg[0];
    assign count     = count_reg;

    // Credit accounting upstream must never let the buffer overflow.
    overflow_check : assert property (@(posedge clock) disable iff (reset)
        !(push && !pop && count_reg == 2'd2));

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder between the PC stage and decode.
// Passes the PC-stage address to a synchronous (1-cycle latency) memory,
// tracks the single in-flight read, and buffers returned words in a 2-entry
// skid FIFO. req_ready is granted only while buffered + in-flight entries
// leave room, so a decode stall never loses an instruction.
//   clock, reset         : clock, asynchronous active-high reset
//   address_imem         : fetch address from the PC stage
//   req_valid/req_ready  : fetch handshake; req_ready is the PC-stage enable
//   flush                : discard buffered and in-flight fetches this cycle
//   stall                : decode cannot take the head instruction
//   mem_address, mem_q   : instruction memory read port
//   instr, instr_pc      : head instruction and its address (0 when invalid)
//   instr_opcode         : instr[31:27]
//   instr_valid          : head entry present
module imem_fetch_responder
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_W,
    parameter int DATA_WIDTH = INSTR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_imem,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  flush,
    input  logic                  stall,
    output logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic [4:0]            instr_opcode,
    output logic                  instr_valid
);

    logic                  inflight_reg;
    logic [ADDR_WIDTH-1:0] inflight_addr_reg;
    logic [1:0]            count;
    logic [2:0]            occupancy;
    logic                  pop;
    logic                  push;
    logic                  accept;
    logic [DATA_WIDTH-1:0] head_data;
    logic [ADDR_WIDTH-1:0] head_addr;

    assign mem_address = address_imem;

    assign instr_valid = (count != 2'd0);
    // A flush drops the head rather than handing it to decode.
    assign pop         = instr_valid & ~stall & ~flush;
    // Credits: an in-flight read already owns a FIFO slot; a same-cycle pop
    // frees one.
    assign occupancy   = {1'b0, count} + {2'b0, inflight_reg};
    assign req_ready   = ~flush & ((occupancy < 3'd2) | pop);
    assign accept      = req_valid & req_ready;
    // Memory data returning during a flush belongs to the discarded path.
    assign push        = inflight_reg & ~flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_reg      <= 1'b0;
            inflight_addr_reg <= '0;
        end else begin
            inflight_reg <= accept;
            if (accept) begin
                inflight_addr_reg <= address_imem;
            end
        end
    end

    fetch_skid_fifo #(
        .DATA_W (DATA_WIDTH),
        .ADDR_W (ADDR_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (mem_q),
        .push_addr (inflight_addr_reg),
        .pop       (pop),
        .clear     (flush),
        .head_data (head_data),
        .head_addr (head_addr),
        .count     (count)
    );

    assign instr        = instr_valid ? head_data : DATA_WIDTH'(NOP_INSTR);
    assign instr_pc     = instr_valid ? head_addr : '0;
    assign instr_opcode = instr[OPCODE_MSB:OPCODE_LSB];

endmodule
